uart_rx_deserializer: RTL and testbench
=======================================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit period (even, >=8).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock, all flops on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx_serial  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  DATA_BITS  last accepted frame data, LSB = first bit received; drives parity checker data_in.
REQ-008 SHALL have port parity_bit  output  1  received parity bit of last accepted frame; drives parity checker rx_in.
REQ-009 SHALL have port parity_check  output  1  one-clk strobe: data_out/parity_bit newly valid; drives parity checker parity_check.
REQ-010 SHALL have port frame_error  output  1  one-clk strobe: stop bit sampled low.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL pass rx_serial through a 2-flop synchronizer (rx_s, reset value 1) before any use; all sampling uses rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; tick_cnt and bit_cnt advance only on clk edges where baud_tick=1.
REQ-014 IDLE: when armed=1, baud_tick=1 and rx_s=0 -> START, tick_cnt=0.
REQ-015 START: when tick_cnt reaches OVERSAMPLE/2-1 (7), sample rx_s; 0 -> DATA, tick_cnt=0, bit_cnt=0; 1 -> IDLE (glitch rejected, no strobe).
REQ-016 DATA: when tick_cnt reaches OVERSAMPLE-1 (15), shift rx_s into shift register LSB-first, tick_cnt=0, bit_cnt+1; after DATA_BITS-th sample -> PARITY.
REQ-017 PARITY: when tick_cnt reaches OVERSAMPLE-1, capture rx_s as internal parity, tick_cnt=0 -> STOP.
REQ-018 STOP: when tick_cnt reaches OVERSAMPLE-1, sample rx_s; 1 -> load data_out and parity_bit from internal registers and pulse parity_check for exactly that one clk; 0 -> pulse frame_error, data_out/parity_bit unchanged, clear armed. Both cases -> IDLE.
REQ-019 armed SHALL set on any baud_tick with rx_s=1 in IDLE; clear only per REQ-018 or reset (prevents break/stuck-low line retriggering).
REQ-020 parity_check and frame_error SHALL never be high in the same cycle; each strobes at most once per frame.
REQ-021 data_out and parity_bit SHALL be registered and stable between parity_check strobes, valid in the same cycle as the strobe.
REQ-022 baud_tick=0 SHALL freeze state, tick_cnt and bit_cnt.
REQ-023 Parity SHALL NOT be evaluated here; only transported.

Reset
REQ-024 reset=0 SHALL immediately force state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, armed=0, rx_s/sync flops=1.
REQ-025 Reset values: data_out=0, parity_bit=0, parity_check=0, frame_error=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame without any strobe.

Structure
REQ-027 State encodings, OVERSAMPLE and DATA_BITS defaults SHALL live in the shared uart definitions package/include used by the TX side.
REQ-028 Synchronizer SHALL be a separate sub-module uart_rx_sync (2-flop, reset-to-1).
REQ-029 Counter widths SHALL be clog2(OVERSAMPLE) and clog2(DATA_BITS+1).

Verification
REQ-030 Frame 0xA5, parity 1, stop 1 at 16x ticks -> one parity_check pulse, data_out=8'hA5, parity_bit=1, frame_error=0.
REQ-031 Back-to-back frames 0x00/p=1 then 0xFF/p=1, no idle gap -> two parity_check pulses, data_out 8'h00 then 8'hFF.
REQ-032 Low glitch of 4 ticks on idle line -> returns to IDLE, no strobes, data_out unchanged.
REQ-033 Frame 0x3C with stop bit 0, then line held low 40 bit-times, then high -> one frame_error pulse, no parity_check, no new START until line returns high.
REQ-034 reset asserted during bit 4 of frame 0x5A, released, then frame 0x81/p=1 -> outputs at reset values, no strobe for 0x5A, then data_out=8'h81 with one parity_check.
REQ-035 baud_tick held low 100 clks mid-DATA, then resumed -> frame completes correctly with identical data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX and TX sides: default frame geometry
// and the receiver state encoding.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to 1
// so the line reads idle while reset is applied.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start/data/parity/stop deserializer that hands the
// data word and raw parity bit to a downstream parity checker.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_bit,
  output logic                 parity_check,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_e       r_state,    w_state_nxt;
  logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
  logic [BW-1:0]        r_bit_cnt,  w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic                 r_par_int,  w_par_int_nxt;
  logic                 r_armed,    w_armed_nxt;
  logic                 w_load;
  logic                 w_ferr;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_parity_bit;
  logic                 r_parity_check;
  logic                 r_frame_error;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx_serial),
    .o_sync  (w_rx_s)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_int_nxt = r_par_int;
    w_armed_nxt   = r_armed;
    w_load        = 1'b0;
    w_ferr        = 1'b0;

    if (baud_tick) begin
      case (r_state)
        ST_IDLE: begin
          // Only a high-to-low transition may start a frame; a stuck-low line never re-arms.
          if (w_rx_s) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_state_nxt = ST_START;
            w_tick_nxt  = '0;
          end
        end
        ST_START: begin
          if (r_tick_cnt == TICK_MID) begin
            w_tick_nxt = '0;
            if (w_rx_s) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_DATA;
              w_bit_nxt   = '0;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tick_cnt == TICK_END) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = ST_PARITY;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_tick_cnt == TICK_END) begin
            w_tick_nxt    = '0;
            w_par_int_nxt = w_rx_s;
            w_state_nxt   = ST_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_tick_cnt == TICK_END) begin
            w_tick_nxt  = '0;
            w_state_nxt = ST_IDLE;
            if (w_rx_s) begin
              w_load = 1'b1;
            end else begin
              w_ferr      = 1'b1;
              w_armed_nxt = 1'b0;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_par_int      <= 1'b0;
      r_armed        <= 1'b0;
      r_data_out     <= '0;
      r_parity_bit   <= 1'b0;
      r_parity_check <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_tick_cnt     <= w_tick_nxt;
      r_bit_cnt      <= w_bit_nxt;
      r_shift        <= w_shift_nxt;
      r_par_int      <= w_par_int_nxt;
      r_armed        <= w_armed_nxt;
      r_parity_check <= w_load;
      r_frame_error  <= w_ferr;
      if (w_load) begin
        r_data_out   <= r_shift;
        r_parity_bit <= r_par_int;
      end
    end
  end

  assign data_out     = r_data_out;
  assign parity_bit   = r_parity_bit;
  assign parity_check = r_parity_check;
  assign frame_error  = r_frame_error;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and randomized frames against a frame-level model: each sent frame
// predicts one parity_check (good stop) or one frame_error (bad stop) event.
module tb_uart_rx_deserializer;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int TICK_DIV = 3;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       par;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx_serial;
  logic [7:0] data_out;
  logic       parity_bit;
  logic       parity_check;
  logic       frame_error;
  logic       busy;

  logic       tick_en   = 1'b1;
  logic       low_watch = 1'b0;
  int         busy_hits = 0;
  int         n_pass    = 0;
  int         n_fail    = 0;
  int         n_total   = 0;

  evt_t       exp_q[$];
  evt_t       obs_q[$];
  logic [7:0] last_data = 8'h00;
  logic       last_par  = 1'b0;
  logic [7:0] prev_data;
  logic       prev_par;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .rx_serial    (rx_serial),
    .data_out     (data_out),
    .parity_bit   (parity_bit),
    .parity_check (parity_check),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Baud tick: one clk high every TICK_DIV clks, frozen while tick_en is low.
  initial begin
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div = (div == TICK_DIV - 1) ? 0 : div + 1;
        baud_tick = (div == 0);
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  // Event monitor: records strobes and watches output stability between strobes.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (parity_check || frame_error) begin
          check("strobe_exclusive", {31'b0, parity_check & frame_error}, 32'd0);
          e.ferr = frame_error;
          e.data = data_out;
          e.par  = parity_bit;
          obs_q.push_back(e);
        end
        if (!parity_check && ({data_out, parity_bit} !== {prev_data, prev_par}))
          check("hold_stable", {23'b0, data_out, parity_bit}, {23'b0, prev_data, prev_par});
        if (low_watch && busy) busy_hits++;
      end
      prev_data = data_out;
      prev_par  = parity_bit;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic hold(input logic level, input int n);
    int c;
    c = 0;
    rx_serial = level;
    while (c < n) begin
      @(posedge clk);
      if (baud_tick) c++;
    end
    @(negedge clk);
  endtask

  task automatic pause_ticks(input int n);
    tick_en = 1'b0;
    repeat (n) @(negedge clk);
    check("freeze_busy", {31'b0, busy}, 32'd1);
    tick_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int pause_bit);
    evt_t e;
    logic [7:0] dv;
    dv = d;
    hold(1'b0, OS);
    for (int i = 0; i < DB; i++) begin
      if (i == pause_bit) begin
        hold(dv[i], OS / 2);
        pause_ticks(100);
        hold(dv[i], OS / 2);
      end else begin
        hold(dv[i], OS);
      end
    end
    hold(p, OS);
    hold(stop, OS);
    if (stop) begin
      last_data = d;
      last_par  = p;
    end
    e.ferr = !stop;
    e.data = last_data;
    e.par  = last_par;
    exp_q.push_back(e);
  endtask

  task automatic settle_and_compare(input string tag);
    hold(1'b1, 2 * OS);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_evt"}, {22'b0, obs_q[i]}, {22'b0, exp_q[i]});
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_data"}, {23'b0, data_out, parity_bit}, {23'b0, last_data, last_par});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    int         gap;

    reset     = 1'b0;
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data",   {24'b0, data_out}, 32'd0);
    check("rst_parity", {31'b0, parity_bit}, 32'd0);
    check("rst_pchk",   {31'b0, parity_check}, 32'd0);
    check("rst_ferr",   {31'b0, frame_error}, 32'd0);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 2 * OS);

    send_frame(8'hA5, 1'b1, 1'b1, -1);
    settle_and_compare("a5");

    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    settle_and_compare("b2b");

    hold(1'b0, 4);
    hold(1'b1, OS);
    settle_and_compare("glitch");

    send_frame(8'h3C, 1'b0, 1'b0, -1);
    busy_hits = 0;
    low_watch = 1'b1;
    hold(1'b0, 40 * OS);
    low_watch = 1'b0;
    check("stuck_low_busy", busy_hits, 32'd0);
    settle_and_compare("ferr");
    send_frame(8'h42, 1'b0, 1'b1, -1);
    settle_and_compare("rearm");

    d = 8'h5A;
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(d[i], OS);
    hold(d[4], OS / 2);
    #2 reset = 1'b0;
    #1;
    check("midrst_data", {24'b0, data_out}, 32'd0);
    check("midrst_par",  {31'b0, parity_bit}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    #2 reset = 1'b1;
    last_data = 8'h00;
    last_par  = 1'b0;
    @(negedge clk);
    hold(1'b1, OS);
    check("postrst_data", {24'b0, data_out}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, -1);
    settle_and_compare("postrst");

    send_frame(8'hC6, 1'b0, 1'b1, 3);
    settle_and_compare("freeze");

    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom);
      p   = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 5) != 0);
      gap = s ? $urandom_range(0, 12) : $urandom_range(4, 12);
      send_frame(d, p, s, -1);
      if (gap > 0) hold(1'b1, gap);
    end
    settle_and_compare("rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
